// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/func constants, control-word layout and encodings for the decode stage
// Contents: OP_*/FN_* instruction constants, ALU/FPU/jump encodings,
//           ctrl_t packed control word, CTRL_W and per-field bit offsets.
package cpu_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_FPU   = 6'h11;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_XORI  = 6'h0e;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [5:0] FN_ADDS  = 6'h00;
    localparam logic [5:0] FN_MULS  = 6'h02;
    localparam logic [5:0] FN_DIVS  = 6'h03;
    localparam logic [5:0] FN_SQRTS = 6'h04;
    localparam logic [5:0] FN_MULIS = 6'h05;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT} alu_op_e;
    typedef enum logic [2:0] {FPU_ADD, FPU_MUL, FPU_DIV, FPU_SQRT, FPU_MULI} fpu_op_e;
    typedef enum logic [1:0] {JMP_NONE, JMP_TARGET, JMP_REG} jump_e;

    // First member is the MSB of the packed word.
    typedef struct packed {
        logic    branch;
        logic    reg_write;
        logic    mem_write;
        logic    alu_src;
        logic    jal;
        logic    fp_reg_write;
        logic    fp_alu_src;
        jump_e   jump;
        logic    reg_dst;
        logic    mem_to_reg;
        logic    fp_reg_dst;
        alu_op_e alu_ctrl;
        fpu_op_e fp_alu_ctrl;
    } ctrl_t;

    localparam int CTRL_W            = $bits(ctrl_t);
    localparam int CTRL_FP_ALU_LSB   = 0;
    localparam int CTRL_ALU_LSB      = 3;
    localparam int CTRL_FP_REG_DST   = 6;
    localparam int CTRL_MEM_TO_REG   = 7;
    localparam int CTRL_REG_DST      = 8;
    localparam int CTRL_JUMP_LSB     = 9;
    localparam int CTRL_FP_ALU_SRC   = 11;
    localparam int CTRL_FP_REG_WRITE = 12;
    localparam int CTRL_JAL          = 13;
    localparam int CTRL_ALU_SRC      = 14;
    localparam int CTRL_MEM_WRITE    = 15;
    localparam int CTRL_REG_WRITE    = 16;
    localparam int CTRL_BRANCH       = 17;
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational MIPS-subset decoder
// Ports: instruction (in); ctrl, illegal, rs/rt/rd, immediate, target,
//        fp_dst (FP destination register), is_fpu, fp_long (div.s/sqrt.s) (out).
module decode_comb
    import cpu_pkg::*;
(
    input  logic [31:0]       instruction,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       immediate,
    output logic [25:0]       target,
    output logic [4:0]        fp_dst,
    output logic              is_fpu,
    output logic              fp_long
);
    logic [5:0] w_op;
    logic [5:0] w_fn;
    ctrl_t      w_c;
    logic       w_ill;

    assign w_op      = instruction[31:26];
    assign w_fn      = instruction[5:0];
    assign rs        = instruction[25:21];
    assign rt        = instruction[20:16];
    assign rd        = instruction[15:11];
    assign target    = instruction[25:0];
    assign immediate = (w_op == OP_JAL) ? 16'd8 : instruction[15:0];
    assign is_fpu    = w_op == OP_FPU;
    assign fp_long   = is_fpu && (w_fn == FN_DIVS || w_fn == FN_SQRTS);
    assign ctrl      = w_ill ? {CTRL_W{1'b0}} : w_c;
    assign illegal   = w_ill;
    assign fp_dst    = ctrl[CTRL_FP_REG_DST] ? rd : rt;

    always_comb begin
        w_c   = '0;
        w_ill = 1'b0;
        case (w_op)
            OP_LW: begin
                w_c.reg_write  = 1'b1;
                w_c.alu_src    = 1'b1;
                w_c.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                w_c.mem_write = 1'b1;
                w_c.alu_src   = 1'b1;
            end
            OP_J: w_c.jump = JMP_TARGET;
            OP_JAL: begin
                w_c.jump      = JMP_TARGET;
                w_c.jal       = 1'b1;
                w_c.reg_write = 1'b1;
            end
            OP_BNE: begin
                w_c.branch   = 1'b1;
                w_c.alu_ctrl = ALU_SUB;
            end
            OP_ADDI: begin
                w_c.reg_write = 1'b1;
                w_c.alu_src   = 1'b1;
            end
            OP_RTYPE: begin
                w_c.reg_write = w_fn != FN_JR;
                w_c.reg_dst   = w_fn != FN_JR;
                case (w_fn)
                    FN_ADD:  w_c.alu_ctrl = ALU_ADD;
                    FN_SUB:  w_c.alu_ctrl = ALU_SUB;
                    FN_XORI: w_c.alu_ctrl = ALU_XOR;
                    FN_SLT:  w_c.alu_ctrl = ALU_SLT;
                    FN_JR:   w_c.jump     = JMP_REG;
                    default: w_ill        = 1'b1;
                endcase
            end
            OP_FPU: begin
                // muli.s takes an immediate operand and writes rt; the rest write rd
                w_c.fp_reg_write = 1'b1;
                w_c.fp_reg_dst   = w_fn != FN_MULIS;
                w_c.fp_alu_src   = w_fn == FN_MULIS;
                case (w_fn)
                    FN_ADDS:  w_c.fp_alu_ctrl = FPU_ADD;
                    FN_MULS:  w_c.fp_alu_ctrl = FPU_MUL;
                    FN_DIVS:  w_c.fp_alu_ctrl = FPU_DIV;
                    FN_SQRTS: w_c.fp_alu_ctrl = FPU_SQRT;
                    FN_MULIS: w_c.fp_alu_ctrl = FPU_MULI;
                    default:  w_ill           = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: pipelined decode register with valid/ready handshake and FPU busy scoreboard
// Ports: clk, reset (async, active-high); in_valid/in_ready/instruction (upstream);
//        out_valid/out_ready, ctrl, rs/rt/rd, immediate, target, illegal (downstream);
//        fp_busy (multicycle FPU op outstanding).
module decode_stage
    import cpu_pkg::*;
#(
    parameter int FP_DIV_LAT  = 8,
    parameter int FP_SQRT_LAT = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       immediate,
    output logic [25:0]       target,
    output logic              illegal,
    output logic              fp_busy
);
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_illegal;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [15:0]       w_imm;
    logic [25:0]       w_target;
    logic [4:0]        w_fp_dst;
    logic              w_is_fpu;
    logic              w_fp_long;
    logic              w_hazard;
    logic              w_accept;
    logic              w_load;

    logic              r_out_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic [15:0]       r_imm;
    logic [25:0]       r_target;
    logic              r_illegal;
    logic [7:0]        r_cnt;
    logic [4:0]        r_busy_reg;

    decode_comb u_dec (
        .instruction (instruction),
        .ctrl        (w_ctrl),
        .illegal     (w_illegal),
        .rs          (w_rs),
        .rt          (w_rt),
        .rd          (w_rd),
        .immediate   (w_imm),
        .target      (w_target),
        .fp_dst      (w_fp_dst),
        .is_fpu      (w_is_fpu),
        .fp_long     (w_fp_long)
    );

    assign fp_busy  = r_cnt != 8'd0;
    // Any FPU op touching the busy register, or a second long op, waits for the counter to reach 0.
    assign w_hazard = fp_busy && in_valid && w_is_fpu &&
                      (w_rs == r_busy_reg || w_rt == r_busy_reg || w_fp_dst == r_busy_reg || w_fp_long);
    assign in_ready = !reset && (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && !w_illegal && w_fp_long;

    assign out_valid = r_out_valid;
    assign ctrl      = r_ctrl;
    assign rs        = r_rs;
    assign rt        = r_rt;
    assign rd        = r_rd;
    assign immediate = r_imm;
    assign target    = r_target;
    assign illegal   = r_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_target    <= '0;
            r_illegal   <= 1'b0;
            r_cnt       <= '0;
            r_busy_reg  <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_ctrl      <= w_ctrl;
                r_rs        <= w_rs;
                r_rt        <= w_rt;
                r_rd        <= w_rd;
                r_imm       <= w_imm;
                r_target    <= w_target;
                r_illegal   <= w_illegal;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_load) begin
                r_cnt      <= (w_ctrl[CTRL_FP_ALU_LSB +: 3] == FPU_DIV) ? 8'(FP_DIV_LAT) : 8'(FP_SQRT_LAT);
                r_busy_reg <= w_fp_dst;
            end else if (fp_busy) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter FP_DIV_LAT, default 8: cycles fpu div.s holds its destination busy (range 2..255).
REQ-002 SHALL have parameter FP_SQRT_LAT, default 12: cycles fpu sqrt.s holds its destination busy (range 2..255).
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: the instruction input is valid.
REQ-006 SHALL have port in_ready, output, 1: the stage accepts the instruction this cycle.
REQ-007 SHALL have port instruction, input, 32: the raw MIPS-subset word.
REQ-008 SHALL have port out_valid, output, 1: the decoded bundle is valid.
REQ-009 SHALL have port out_ready, input, 1: downstream takes the bundle.
REQ-010 SHALL have port ctrl, output, CTRL_W: packed control word (branch, reg_write, mem_write, alu_src, jal, fp_reg_write, fp_alu_src, jump, reg_dst, mem_to_reg, fp_reg_dst, alu_ctrl, fp_alu_ctrl).
REQ-011 SHALL have port rs/rt/rd, output, 5 each: instruction[25:21]/[20:16]/[15:11].
REQ-012 SHALL have port immediate, output, 16: instruction[15:0], or 8 for JAL.
REQ-013 SHALL have port target, output, 26: instruction[25:0].
REQ-014 SHALL have port illegal, output, 1: unknown opcode or func; all write enables forced to 0.
REQ-015 SHALL have port fp_busy, output, 1: a multicycle FPU op is outstanding.

Function
REQ-016 SHALL decode LW 0x23, SW 0x2b, J 0x2, JAL 0x3, BNE 0x5, ADDI 0x8; R-type (op 0) funcs XORI 0xe, ADD 0x20, SUB 0x22, SLT 0x2a, JR 0x8; FPU (op 0x11) funcs add.s 0, mul.s 2, div.s 3, sqrt.s 4, muli.s 5, using the established control-word encodings.
REQ-017 SHALL drive 0 on every don't-care control field; no X on ctrl.
REQ-018 SHALL assert in_ready = (!out_valid || out_ready) && !hazard.
REQ-019 SHALL accept on in_valid && in_ready and present the decoded bundle with out_valid=1 on the next edge (latency 1).
REQ-020 SHALL hold ctrl, rs, rt, rd, immediate, target and illegal stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid after out_ready when no new accept occurs; an accept and a drain in the same cycle give back-to-back bundles with no bubble.
REQ-022 SHALL compute the FP destination as rd when fp_reg_dst=1 and rt otherwise.
REQ-023 SHALL, on accepting div.s or sqrt.s, load the busy counter with FP_DIV_LAT or FP_SQRT_LAT and latch busy_reg = the FP destination.
REQ-024 SHALL decrement the counter each cycle while it is nonzero; fp_busy = (counter != 0).
REQ-025 SHALL set hazard = fp_busy && in_valid && FPU opcode && (rs, rt or FP destination == busy_reg, or the op is div.s/sqrt.s).
REQ-026 SHALL evaluate hazard from the registered counter, so a dependent op is accepted in the cycle the counter reads 0.
REQ-027 SHALL never raise hazard on a non-FPU instruction.
REQ-028 SHALL never set the busy counter or busy_reg from an illegal instruction.

Reset
REQ-029 SHALL, on reset at any time including mid-division, clear out_valid, illegal, ctrl, rs, rt, rd, immediate, target, the busy counter, busy_reg and fp_busy immediately.
REQ-030 SHALL hold in_ready at 0 while reset is asserted and at 1 in the first cycle after release.

Structure
REQ-031 SHALL place opcode/func constants, the ctrl field offsets and CTRL_W in a shared package, cpu_pkg.
REQ-032 SHALL contain one combinational sub-module, decode_comb (instruction in, ctrl/illegal out); the handshake register and scoreboard stay in decode_stage.

Verification
REQ-033 SHALL check: 0x20080005 (addi $8,$0,5) accepted -> next cycle out_valid=1, reg_write=1, alu_src=1, rt=8, immediate=0x0005.
REQ-034 SHALL check: out_ready=0 for 3 cycles with in_valid=1 -> bundle unchanged and in_ready=0 for those cycles, then 2 bundles drain back-to-back.
REQ-035 SHALL check: 0x44001003 (div.s f2) then 0x44402000 (add.s f4,f2) -> in_ready=0 for 8 cycles and fp_busy=1, accept on the 9th cycle.
REQ-036 SHALL check: div.s f2 then 0x20080005 -> ADDI accepted the cycle after, with no stall.
REQ-037 SHALL check: 0xFC000000 -> illegal=1, reg_write=mem_write=fp_reg_write=0.
REQ-038 SHALL check: reset 3 cycles after div.s issue -> fp_busy=0 and out_valid=0 immediately; dependent add.s accepted in the first cycle after release.
